// File: rtl/sensors_poller_if.sv
// Bus between the sensor poller and its environment: scan control, the
// per-sensor req/ack handshake and the committed frame outputs.
interface sensors_poller_if;
  logic        start_i;
  logic        req_o;
  logic [2:0]  sel_o;
  logic        ack_i;
  logic [7:0]  data_i;
  logic [39:0] sensors_data_o;
  logic [4:0]  sensors_en_o;
  logic [4:0]  fault_o;
  logic        busy_o;
  logic        frame_valid_o;

  // Poller side
  modport master (
    input  start_i, ack_i, data_i,
    output req_o, sel_o, sensors_data_o, sensors_en_o, fault_o, busy_o, frame_valid_o
  );

  // Sensor / host side
  modport slave (
    output start_i, ack_i, data_i,
    input  req_o, sel_o, sensors_data_o, sensors_en_o, fault_o, busy_o, frame_valid_o
  );
endinterface

// File: rtl/sensors_poller.sv
// Sequential acquisition front-end: polls five sensors over req/ack, marks
// timed-out or out-of-range readings inactive, and commits one coherent
// data word / enable mask / fault mask per scan with a one-cycle strobe.
module sensors_poller #(
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] MAX_TEMP = 8'd125
) (
  input logic              clk_i,
  input logic              rst_i,
  sensors_poller_if.master bus
);

  localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DONE} state_t;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic [39:0]   r_stg_data;
  logic [4:0]    r_stg_en;
  logic [4:0]    r_stg_fault;

  logic          r_req;
  logic          r_busy;
  logic          r_fv;
  logic [39:0]   r_data;
  logic [4:0]    r_en;
  logic [4:0]    r_fault;

  logic          w_ack_ok;
  logic          w_ack_bad;
  logic          w_tmo;
  logic          w_resolve;
  logic [39:0]   w_stg_data;
  logic [4:0]    w_stg_en;
  logic [4:0]    w_stg_fault;

  function automatic logic in_range(input logic [7:0] d);
    return (d <= MAX_TEMP);
  endfunction

  // Resolve the current sensor and build the staging values it would leave behind
  always_comb begin
    w_ack_ok    = (r_state == S_REQ) && bus.ack_i && in_range(bus.data_i);
    w_ack_bad   = (r_state == S_REQ) && bus.ack_i && !in_range(bus.data_i);
    w_tmo       = (r_state == S_REQ) && !bus.ack_i && (r_timer == TLAST);
    w_resolve   = w_ack_ok || w_ack_bad || w_tmo;
    w_stg_data  = r_stg_data;
    w_stg_en    = r_stg_en;
    w_stg_fault = r_stg_fault;
    for (int k = 0; k < 5; k++) begin
      if (r_idx == 3'(k)) begin
        if (w_ack_ok) begin
          w_stg_data[k*8 +: 8] = bus.data_i;
          w_stg_en[k]          = 1'b1;
          w_stg_fault[k]       = 1'b0;
        end else if (w_ack_bad || w_tmo) begin
          w_stg_data[k*8 +: 8] = 8'd0;
          w_stg_en[k]          = 1'b0;
          w_stg_fault[k]       = 1'b1;
        end
      end
    end
  end

  // Scan FSM with registered handshake, status and committed frame outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_timer     <= '0;
      r_stg_data  <= '0;
      r_stg_en    <= '0;
      r_stg_fault <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_fv        <= 1'b0;
      r_data      <= '0;
      r_en        <= '0;
      r_fault     <= '0;
    end else begin
      r_fv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_stg_data  <= '0;
            r_stg_en    <= '0;
            r_stg_fault <= '0;
            r_idx       <= 3'd0;
            r_timer     <= '0;
            r_req       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_resolve) begin
            r_stg_data  <= w_stg_data;
            r_stg_en    <= w_stg_en;
            r_stg_fault <= w_stg_fault;
            r_req       <= 1'b0;
            if (r_idx == 3'd4) begin
              // Last sensor resolved: commit the whole frame in one step
              r_data  <= w_stg_data;
              r_en    <= w_stg_en;
              r_fault <= w_stg_fault;
              r_fv    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_timer <= '0;
              r_state <= S_GAP;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_GAP: begin
          r_req   <= 1'b1;
          r_state <= S_REQ;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_o          = r_req;
  assign bus.sel_o          = r_idx;
  assign bus.busy_o         = r_busy;
  assign bus.frame_valid_o  = r_fv;
  assign bus.sensors_data_o = r_data;
  assign bus.sensors_en_o   = r_en;
  assign bus.fault_o        = r_fault;

endmodule

// File: tb/tb_sensors_poller.sv
// Bench for sensors_poller: table of scan scenarios with a sensor responder,
// expected frames queued at start and compared at frame_valid, plus a
// hand-written mid-scan reset sequence.
module tb_sensors_poller;

  localparam logic [5:0] NEVER = 6'd63;

  logic clk;
  logic rst;

  sensors_poller_if bus ();

  sensors_poller #(.TIMEOUT(16), .MAX_TEMP(8'd125)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][5:0] dly;   // REQ cycles before ack per sensor, NEVER = no ack
    logic [4:0][7:0] val;   // value returned per sensor
    logic            noise; // spurious start during REQ/DONE, ack during GAP
    logic [39:0]     exp_data;
    logic [4:0]      exp_en;
    logic [4:0]      exp_fault;
    logic [7:0]      exp_lat;
  } vec_t;

  typedef struct packed {
    logic [39:0] data;
    logic [4:0]  en;
    logic [4:0]  fault;
    logic [7:0]  lat;
  } exp_t;

  vec_t        tbl [7];
  exp_t        sb_q [$];
  int          checks;
  int          failures;
  logic [39:0] prev_data;
  logic [4:0]  prev_en;
  logic [4:0]  prev_fault;

  function automatic vec_t mkv(input logic [29:0] dly, input logic [39:0] val, input logic noise,
                               input logic [39:0] d, input logic [4:0] en, input logic [4:0] f,
                               input logic [7:0] lat);
    vec_t v;
    v.dly = dly; v.val = val; v.noise = noise;
    v.exp_data = d; v.exp_en = en; v.exp_fault = f; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_scan(input int id, input vec_t v);
    int   k, reqcnt, gapcnt, s;
    bit   seen, hold_ok;
    exp_t e;
    sb_q.push_back('{data: v.exp_data, en: v.exp_en, fault: v.exp_fault, lat: v.exp_lat});
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.ack_i   = 1'b0;
    k = 0; reqcnt = 0; gapcnt = 0; seen = 0; hold_ok = 1;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      bus.start_i = v.noise ? bus.req_o : 1'b0;
      if (bus.frame_valid_o) begin
        seen = 1;
        e = sb_q.pop_front();
        check($sformatf("v%0d_data", id), bus.sensors_data_o, e.data);
        check($sformatf("v%0d_en", id), 40'(bus.sensors_en_o), 40'(e.en));
        check($sformatf("v%0d_fault", id), 40'(bus.fault_o), 40'(e.fault));
        check($sformatf("v%0d_latency", id), 40'(k), 40'(e.lat));
        check($sformatf("v%0d_gap_cycles", id), 40'(gapcnt), 40'd4);
        check($sformatf("v%0d_hold_busy", id), 40'(hold_ok), 40'd1);
        check($sformatf("v%0d_done_busy", id), 40'(bus.busy_o), 40'd1);
        bus.ack_i   = 1'b0;
        bus.start_i = v.noise;
      end else begin
        if (bus.sensors_data_o !== prev_data || bus.sensors_en_o !== prev_en ||
            bus.fault_o !== prev_fault || bus.busy_o !== 1'b1)
          hold_ok = 0;
        if (bus.req_o) begin
          reqcnt++;
          s = int'(bus.sel_o);
          if (s < 5 && v.dly[s] != NEVER && reqcnt == int'(v.dly[s]) + 1) begin
            bus.ack_i  = 1'b1;
            bus.data_i = v.val[s];
          end else begin
            bus.ack_i  = 1'b0;
            bus.data_i = 8'h00;
          end
        end else begin
          reqcnt = 0;
          gapcnt++;
          bus.ack_i  = v.noise;
          bus.data_i = v.noise ? 8'h11 : 8'h00;
        end
      end
    end
    if (!seen) begin
      failures++;
      checks++;
      $display("FAIL v%0d_frame_timeout actual=none required=frame_valid", id);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      bus.start_i = 1'b0;
      bus.ack_i   = 1'b0;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    check($sformatf("v%0d_idle_busy", id), 40'(bus.busy_o), 40'd0);
    check($sformatf("v%0d_fv_one_cycle", id), 40'(bus.frame_valid_o), 40'd0);
    @(negedge clk);
    check($sformatf("v%0d_no_restart", id), 40'(bus.req_o), 40'd0);
    prev_data  = v.exp_data;
    prev_en    = v.exp_en;
    prev_fault = v.exp_fault;
  endtask

  task automatic reset_mid_scan();
    int  n;
    bit  quiet;
    @(negedge clk);
    bus.start_i = 1'b1;
    n = 0;
    while (!(bus.req_o && bus.sel_o == 3'd3) && n < 100) begin
      @(negedge clk);
      n++;
      bus.start_i = 1'b0;
      bus.ack_i   = bus.req_o;
      bus.data_i  = 8'h33;
    end
    check("rst_reached_sensor3", 40'(bus.sel_o), 40'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.ack_i = 1'b0;
    check("rst_req", 40'(bus.req_o), 40'd0);
    check("rst_sel", 40'(bus.sel_o), 40'd0);
    check("rst_data", bus.sensors_data_o, 40'd0);
    check("rst_en", 40'(bus.sensors_en_o), 40'd0);
    check("rst_fault", 40'(bus.fault_o), 40'd0);
    check("rst_busy", 40'(bus.busy_o), 40'd0);
    check("rst_fv", 40'(bus.frame_valid_o), 40'd0);
    quiet = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.frame_valid_o || bus.req_o || bus.busy_o) quiet = 0;
    end
    check("rst_abandoned_quiet", 40'(quiet), 40'd1);
    prev_data  = '0;
    prev_en    = '0;
    prev_fault = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    prev_data = '0; prev_en = '0; prev_fault = '0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.ack_i   = 1'b0;
    bus.data_i  = 8'h00;

    //            dly (s4..s0)                          val (s4..s0)   noise data            en        fault     lat
    tbl[0] = mkv({6'd0, 6'd0, 6'd0, 6'd0, 6'd0},        40'h1817161514, 1'b0, 40'h1817161514, 5'b11111, 5'b00000, 8'd10);
    tbl[1] = mkv({6'd0, 6'd0, NEVER, 6'd0, 6'd0},       40'h1E1E1E1E1E, 1'b0, 40'h1E1E001E1E, 5'b11011, 5'b00100, 8'd25);
    tbl[2] = mkv({6'd0, 6'd0, 6'd0, 6'd0, 6'd0},        40'hC87D030201, 1'b0, 40'h007D030201, 5'b01111, 5'b10000, 8'd10);
    tbl[3] = mkv({6'd0, 6'd0, 6'd0, 6'd0, 6'd15},       40'h3C3C3C3C32, 1'b1, 40'h3C3C3C3C32, 5'b11111, 5'b00000, 8'd25);
    tbl[4] = mkv({6'd0, 6'd3, 6'd0, 6'd16, 6'd0},       40'h0909090909, 1'b1, 40'h0909090009, 5'b11101, 5'b00010, 8'd28);
    tbl[5] = mkv({6'd0, 6'd0, 6'd0, 6'd0, 6'd0},        40'h4A49484746, 1'b0, 40'h4A49484746, 5'b11111, 5'b00000, 8'd10);
    tbl[6] = mkv({NEVER, NEVER, NEVER, NEVER, NEVER},   40'h0505050505, 1'b0, 40'h0000000000, 5'b00000, 5'b11111, 8'd85);

    repeat (2) @(negedge clk);
    check("reset_req", 40'(bus.req_o), 40'd0);
    check("reset_busy", 40'(bus.busy_o), 40'd0);
    check("reset_fv", 40'(bus.frame_valid_o), 40'd0);
    check("reset_data", bus.sensors_data_o, 40'd0);
    check("reset_en_fault", 40'({bus.sensors_en_o, bus.fault_o}), 40'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (i == 5) reset_mid_scan();
      run_scan(i, tbl[i]);
    end

    check("scoreboard_empty", 40'(sb_q.size()), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sensors_poller.md
Name: sensors_poller

Overview:
- Sequential acquisition front-end that produces the `sensors_data`/`sensors_en` bus consumed by the temperature-summing stage.
- On each `start_i` pulse it polls the five greenhouse sensors one at a time over a req/ack handshake.
- Readings that time out or are out of range are marked inactive.
- It commits one coherent 40-bit data word and 5-bit enable mask per scan, flagged by a one-cycle `frame_valid_o`.

Parameters:
- `TIMEOUT`, 16: cycles `req_o` stays high per sensor before that sensor is declared dead. Minimum 2.
- `MAX_TEMP`, 8'd125: highest accepted reading. `data_i > MAX_TEMP` is a range fault.

Ports:
- `clk_i`, input, 1: single clock, all logic on rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: scan request. Sampled only in IDLE.
- `req_o`, output, 1: read request to the sensor selected by `sel_o`.
- `sel_o`, output, 3: index (0..4) of the sensor being polled.
- `ack_i`, input, 1: sensor response strobe. Valid only while `req_o`=1.
- `data_i`, input, 8: sensor reading, unsigned. Sampled when `ack_i`=1 and `req_o`=1.
- `sensors_data_o`, output, 40: committed readings. Byte k = sensor k (sensor 0 in [7:0], sensor 4 in [39:32]).
- `sensors_en_o`, output, 5: committed enable mask. Bit k=1 means sensor k delivered a valid reading.
- `fault_o`, output, 5: committed fault mask. Bit k=1 means sensor k timed out or was out of range.
- `busy_o`, output, 1: high from the cycle after `start_i` is accepted through DONE.
- `frame_valid_o`, output, 1: one-cycle strobe; committed outputs updated this cycle.

Behaviour:
- States: IDLE, REQ, GAP, DONE.
  - State register, index register `idx` (3 bit), timer of width $clog2(TIMEOUT).
  - Staging registers: 40-bit data, 5-bit enable, 5-bit fault.
- Reset (`rst_i`=1 at a clock edge, from any state):
  - State goes to IDLE; `idx`, timer and staging are cleared.
  - All outputs read 0 from the next cycle: `req_o`, `sel_o`, `sensors_data_o`, `sensors_en_o`, `fault_o`, `busy_o`, `frame_valid_o`.
  - A scan in progress is abandoned; no `frame_valid_o` is produced.
- IDLE:
  - `busy_o`=0, `req_o`=0.
  - On `start_i`=1: clear staging, set `idx`=0 and timer=0, go to REQ.
- REQ:
  - `req_o`=1, `sel_o`=`idx`, `busy_o`=1.
  - Each cycle:
    - If `ack_i`=1 and `data_i` <= MAX_TEMP: staging byte[idx]=`data_i`, en[idx]=1, fault[idx]=0.
    - Else if `ack_i`=1 (value above MAX_TEMP): byte[idx]=0, en[idx]=0, fault[idx]=1.
    - Else if timer == TIMEOUT-1: byte=0, en=0, fault=1 (timeout).
    - Else: timer+1, stay in REQ.
  - `ack_i` has priority over timeout on the final cycle.
  - On resolve:
    - If `idx`==4, go to DONE.
    - Else `idx`+1, timer=0, go to GAP.
- GAP:
  - `req_o`=0 for exactly one cycle, so consecutive requests are distinct; `busy_o`=1.
  - Next state is REQ.
- DONE:
  - Registered outputs `sensors_data_o`, `sensors_en_o`, `fault_o` take the staging values and first show them in this cycle.
  - `frame_valid_o`=1, `busy_o`=1, `req_o`=0.
  - Next state is IDLE.
- Committed outputs hold between frames. Partial scans are never visible.
- `start_i` while not in IDLE is ignored (not queued). `ack_i` while `req_o`=0 is ignored.
- Latency, start sampled at cycle 0:
  - Best case: `frame_valid_o` at cycle 10 (5 REQ + 4 GAP, then DONE).
  - Each extra wait cycle in REQ adds 1.
  - Worst case: 5·TIMEOUT+4+1 cycles.
- A repeated `start_i` asserted in the DONE cycle is ignored. `start_i` held high restarts a scan on the IDLE cycle after DONE.

Test Plan:
- All sensors ack on the first REQ cycle with 20,21,22,23,24 → `frame_valid_o` at cycle 10, `sensors_data_o`=40'h1817161514, `sensors_en_o`=5'b11111, `fault_o`=0, `req_o` low in GAP cycles.
- TIMEOUT=16, sensor 2 never acks, others ack immediately with 30 → sensor 2 REQ lasts 16 cycles, `frame_valid_o` at cycle 25, `sensors_en_o`=5'b11011, byte2=0, `fault_o`=5'b00100.
- Sensor 4 returns 200, sensor 3 returns 125 (MAX_TEMP=125) → en bit4=0, byte4=0, fault bit4=1; en bit3=1, byte3=8'h7D.
- Sensor 0 acks exactly on its 16th REQ cycle (TIMEOUT=16) → accepted: en bit0=1, fault bit0=0. Ack on the 17th cycle is never seen (already in GAP).
- `start_i` pulsed during REQ and DONE, plus `ack_i` pulsed in GAP/IDLE → no second scan, no state change, staging unaffected; committed outputs change only at DONE.
- `rst_i` asserted while polling sensor 3 after a previous good frame → next cycle all outputs 0, no `frame_valid_o`. A new `start_i` yields a clean frame at cycle 10 with the fresh values.
